// File: rtl/prog_seq_core.sv
// Program sequencer core: computes the next program-memory fetch address each
// clock from the decoder's control strobes, with a small LIFO return stack
// for call/ret and sticky overflow/underflow flags.
module prog_seq_core #(
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             sync_reset,
    input  logic                             jmp,
    input  logic                             jmp_nz,
    input  logic                             dont_jmp,
    input  logic [ADDR_W-1:0]                jmp_addr,
    input  logic                             call,
    input  logic                             ret,
    output logic [ADDR_W-1:0]                pm_addr,
    output logic                             jmp_taken,
    output logic [$clog2(STACK_DEPTH):0]     stack_cnt,
    output logic                             stack_ovf,
    output logic                             stack_unf
);

    localparam int PTR_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              jt_q, jt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

    logic [ADDR_W-1:0] pc_inc;
    logic              stack_full;
    logic              stack_empty;
    logic              push_en;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  top_idx;

    assign pc_inc      = pc_q + ADDR_W'(1);
    assign stack_full  = (cnt_q == CNT_W'(STACK_DEPTH));
    assign stack_empty = (cnt_q == '0);
    // When not full the count is below STACK_DEPTH, so its low bits index the
    // next free slot; the top entry sits one below that.
    assign wr_idx      = cnt_q[PTR_W-1:0];
    assign top_idx     = PTR_W'(cnt_q - CNT_W'(1));

    // Next-state selection: exactly one action per edge, highest priority wins.
    always_comb begin
        pc_d    = pc_inc;
        jt_d    = 1'b0;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_en = 1'b0;
        if (sync_reset) begin
            pc_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if (jmp) begin
            pc_d = jmp_addr;
            jt_d = 1'b1;
        end else if (call) begin
            pc_d = jmp_addr;
            jt_d = 1'b1;
            if (stack_full) begin
                ovf_d = 1'b1;
            end else begin
                push_en = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end else if (ret) begin
            if (stack_empty) begin
                unf_d = 1'b1;
            end else begin
                pc_d  = stack_mem[top_idx];
                cnt_d = cnt_q - CNT_W'(1);
                jt_d  = 1'b1;
            end
        end else if (jmp_nz && !dont_jmp) begin
            pc_d = jmp_addr;
            jt_d = 1'b1;
        end
    end

    // Control state register; async reset forces outputs without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= '0;
            jt_q  <= 1'b0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            jt_q  <= jt_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Return-address storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[wr_idx] <= pc_inc;
        end
    end

    assign pm_addr   = pc_q;
    assign jmp_taken = jt_q;
    assign stack_cnt = cnt_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

endmodule

// File: tb/tb_prog_seq_core.sv
// Bench for prog_seq_core: directed scenarios plus randomized strobes, each
// edge compared against a queue-based reference model.
module tb_prog_seq_core;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;
    localparam int MODV   = 1 << ADDR_W;

    logic              clk;
    logic              reset;
    logic              sync_reset;
    logic              jmp;
    logic              jmp_nz;
    logic              dont_jmp;
    logic [ADDR_W-1:0] jmp_addr;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] pm_addr;
    logic              jmp_taken;
    logic [$clog2(DEPTH):0] stack_cnt;
    logic              stack_ovf;
    logic              stack_unf;

    int n_checks = 0;
    int n_errors = 0;
    int n_steps  = 0;

    // Reference model state
    int m_pc, m_jt, m_ovf, m_unf;
    int m_stk[$];

    prog_seq_core #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .sync_reset(sync_reset), .jmp(jmp),
        .jmp_nz(jmp_nz), .dont_jmp(dont_jmp), .jmp_addr(jmp_addr),
        .call(call), .ret(ret), .pm_addr(pm_addr), .jmp_taken(jmp_taken),
        .stack_cnt(stack_cnt), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_jt = 0; m_ovf = 0; m_unf = 0;
        m_stk.delete();
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pm_addr"},   int'(pm_addr),   m_pc);
        check({tag, ".jmp_taken"}, int'(jmp_taken), m_jt);
        check({tag, ".stack_cnt"}, int'(stack_cnt), m_stk.size());
        check({tag, ".stack_ovf"}, int'(stack_ovf), m_ovf);
        check({tag, ".stack_unf"}, int'(stack_unf), m_unf);
    endtask

    // One clock: apply strobes, advance the model, compare after the edge.
    task automatic step(input bit sr, input bit j, input bit c, input bit r,
                        input bit nz, input bit dj, input int a);
        sync_reset = sr; jmp = j; call = c; ret = r;
        jmp_nz = nz; dont_jmp = dj; jmp_addr = ADDR_W'(a);
        @(posedge clk);
        if (sr) begin
            model_reset();
        end else if (j) begin
            m_pc = a; m_jt = 1;
        end else if (c) begin
            if (m_stk.size() == DEPTH) m_ovf = 1;
            else m_stk.push_back((m_pc + 1) % MODV);
            m_pc = a; m_jt = 1;
        end else if (r) begin
            if (m_stk.size() == 0) begin
                m_pc = (m_pc + 1) % MODV; m_jt = 0; m_unf = 1;
            end else begin
                m_pc = m_stk.pop_back(); m_jt = 1;
            end
        end else if (nz && !dj) begin
            m_pc = a; m_jt = 1;
        end else begin
            m_pc = (m_pc + 1) % MODV; m_jt = 0;
        end
        #1;
        n_steps++;
        $display("step %0d sr=%0b j=%0b c=%0b r=%0b nz=%0b dj=%0b a=%0d -> pm=%0d jt=%0b cnt=%0d ovf=%0b unf=%0b",
                 n_steps, sr, j, c, r, nz, dj, a, pm_addr, jmp_taken, stack_cnt, stack_ovf, stack_unf);
        compare_all("step");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Async reset between edges: outputs must clear before any clock edge.
    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1;
        model_reset();
        $display("async reset -> pm=%0d cnt=%0d", pm_addr, stack_cnt);
        compare_all("async_rst");
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sync_reset = 0; jmp = 0; jmp_nz = 0; dont_jmp = 0;
        jmp_addr = '0; call = 0; ret = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Free-running sequencing with wrap
        idle(17);
        check("seq_wrap", int'(pm_addr), 1);

        // Jumps and suppressed conditional jump
        step(1, 0, 0, 0, 0, 0, 0);
        idle(3);
        step(0, 1, 0, 0, 0, 0, 9);
        check("jmp_target", int'(pm_addr), 9);
        step(0, 0, 0, 0, 1, 1, 2);
        check("jnz_blocked", int'(pm_addr), 10);
        step(0, 0, 0, 0, 1, 0, 2);
        check("jnz_taken", int'(pm_addr), 2);

        // Priority
        step(1, 0, 0, 0, 0, 0, 0);
        idle(5);
        step(1, 1, 0, 0, 0, 0, 7);
        check("prio_sr", int'(pm_addr), 0);
        step(0, 1, 1, 0, 0, 0, 7);
        check("prio_jmp_pc", int'(pm_addr), 7);
        check("prio_jmp_cnt", int'(stack_cnt), 0);

        // Nested call/return
        step(1, 0, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 1, 0, 0, 0, 8);
        step(0, 0, 1, 0, 0, 0, 12);
        check("nest_cnt", int'(stack_cnt), 2);
        step(0, 0, 0, 1, 0, 0, 0);
        check("ret1", int'(pm_addr), 9);
        step(0, 0, 0, 1, 0, 0, 0);
        check("ret2", int'(pm_addr), 2);

        // Overflow / underflow
        step(1, 0, 0, 0, 0, 0, 0);
        idle(14);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0, 4);
        check("ovf_flag", int'(stack_ovf), 1);
        check("ovf_cnt", int'(stack_cnt), 4);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0);
        check("unf_wrap_pc", int'(pm_addr), 0);
        check("unf_flag", int'(stack_unf), 1);
        step(1, 0, 0, 0, 0, 0, 0);
        check("sr_clr_ovf", int'(stack_ovf), 0);

        // Async reset right after a call
        step(0, 0, 1, 0, 0, 0, 6);
        async_reset_pulse();
        check("arst_pc", int'(pm_addr), 0);

        // Randomized strobes
        for (int i = 0; i < 300; i++) begin
            bit sr, j, c, r, nz, dj;
            sr = ($urandom_range(99) < 3);
            j  = ($urandom_range(99) < 10);
            c  = ($urandom_range(99) < 25);
            r  = ($urandom_range(99) < 25);
            nz = ($urandom_range(99) < 25);
            dj = $urandom_range(1);
            step(sr, j, c, r, nz, dj, int'($urandom_range(MODV - 1)));
            if ($urandom_range(99) < 2) async_reset_pulse();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
